mem_byte_sequencer: RTL and testbench
=====================================

// Module: mem_byte_sequencer
// PURPOSE
//  Sequences MEM-stage loads/stores (lw/lhu/lbu, sw/sh/sb) onto a single byte-wide data memory port.
//  Issues 1, 2 or 4 byte beats, holds the pipeline with stall while the access runs, and assembles load data.
//  Sits between the EX/MEM register outputs (MemRead, store type, ALU address, rt data) and the data RAM.
//  Its done pulse lets MEM/WB capture the result.
// PARAMETERS
//  ADDR_W   32   byte-address width for req_addr and mem_addr
//  TIMEOUT  255  maximum cycles a beat waits for mem_ack before aborting with err; 0 disables the timeout
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset_n    in   1       asynchronous active-low reset
//  req_valid  in   1       MEM-stage memory instruction present
//  req_we     in   1       1 = store, 0 = load
//  req_size   in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_addr   in   ADDR_W  effective byte address (ALU result)
//  req_wdata  in   32      store data (rt); low bytes used for sb/sh
//  stall      out  1       freeze IF..MEM stages
//  done       out  1       one-cycle pulse; access finished; rdata valid
//  rdata      out  32      zero-extended load data
//  err        out  1       one-cycle pulse: misaligned, illegal size, or timeout
//  mem_addr   out  ADDR_W  byte address of current beat
//  mem_rd_en  out  1       read beat request
//  mem_wr_en  out  1       write beat request
//  mem_wdata  out  8       write byte
//  mem_rdata  in   8       read byte; valid in the cycle mem_ack=1
//  mem_ack    in   1       beat accepted (and read data valid)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; stall, done, err, mem_rd_en, mem_wr_en = 0; rdata, mem_addr, mem_wdata = 0.
//  Reset mid-access abandons the access immediately. No partial write is completed.
//  Byte order is little-endian: beat k addresses req_addr+k and carries bits [8k+7:8k].
//  Beat count N = 1 for byte, 2 for half, 4 for word.
//  FSM states: IDLE, BEAT, RESP.
//   IDLE: if req_valid, req is latched (addr, wdata, we, size) and a check is made.
//    If size==11, or half with addr[0]!=0, or word with addr[1:0]!=0: err=1 for 1 cycle.
//    On error, no beats are issued, done=0, stall=0, and the state stays IDLE.
//    Otherwise: stall=1 combinationally in that same cycle, beat counter k=0, go to BEAT.
//   BEAT: stall=1. The sequencer drives mem_addr = addr+k, plus mem_rd_en or mem_wr_en.
//    mem_wdata = byte k of the latched wdata. Strobes stay held until mem_ack.
//    On mem_ack: for a load, rdata[8k+7:8k] <= mem_rdata. k++.
//    If k was N-1, go to RESP. Otherwise stay in BEAT with the next beat driven in the next cycle.
//    The wait counter resets on each ack. If it reaches TIMEOUT (TIMEOUT!=0):
//    err=1 for 1 cycle, strobes drop, stall drops, go to IDLE, and done is not raised.
//   RESP: done=1, stall=0, strobes 0. The pipeline advances this cycle.
//    req_valid is ignored in RESP (same instruction). Next state is IDLE.
//  rdata: cleared to 0 on entry to BEAT, so upper bytes are zero for lbu/lhu.
//   rdata holds its value until the next accepted load. It is don't-care for stores.
//  Latency with mem_ack tied high: byte 1+1 cycles (BEAT, RESP), word 4+1. Stall covers IDLE-accept cycle + all BEAT cycles.
//  Back-to-back requests: a new req_valid is accepted in the IDLE cycle directly after RESP.
//  Address arithmetic wraps modulo 2^ADDR_W (aligned accesses never wrap within one access).
//  At most one of mem_rd_en / mem_wr_en is high, and only in BEAT.
// STRUCTURE
//  mips_mem_pkg holds the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), the seq_state_t enum and a beats_for(size) function.
//  Single module. No sub-module is needed; the timeout counter stays inline.
// TESTING
//  1. lw at 0x100, mem_ack=1, RAM bytes 11,22,33,44
//     -> addrs 100..103 read, done after 5 cycles, rdata=0x44332211.
//  2. sh of 0xAABBCCDD at 0x202 with mem_ack=1
//     -> writes DD@202 and CC@203, no other writes, done=1, stall high for 3 cycles.
//  3. lbu at 0x7 with RAM byte 0xF0, and mem_ack delayed 3 cycles
//     -> strobe held for 4 cycles, rdata=0x000000F0, done=1.
//  4. lw at 0x101, then sh at 0x3, then req_size=11
//     -> err pulse each time, mem_rd_en=mem_wr_en=0, stall=0, done=0.
//  5. TIMEOUT=4, sw with mem_ack=0
//     -> err after 4 waiting cycles, stall drops, state IDLE, done never asserted.
//  6. reset_n low during beat 2 of sw
//     -> all outputs 0 at once; after release the next lbu completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage byte sequencer: access sizes, FSM states
// and small helpers for beat count and alignment.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_RESP = 2'd2
  } seq_state_t;

  // Zero beats marks the illegal size encoding.
  function automatic logic [2:0] beats_for(input logic [1:0] size);
    case (size)
      SZ_BYTE: beats_for = 3'd1;
      SZ_HALF: beats_for = 3'd2;
      SZ_WORD: beats_for = 3'd4;
      default: beats_for = 3'd0;
    endcase
  endfunction

  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = addr_lo[0];
      SZ_WORD: req_bad = |addr_lo;
      default: req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// Splits MEM-stage lw/lhu/lbu/sw/sh/sb into little-endian byte beats on an
// 8-bit data RAM port, stalling the pipeline and assembling load data.
module mem_byte_sequencer
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output seq_state_t        dbg_state
);

  // Handshake: a beat's strobe (mem_rd_en/mem_wr_en), mem_addr and mem_wdata
  // stay constant until a cycle with mem_ack=1; that cycle completes the beat
  // and, for reads, mem_rdata is captured in the same cycle.

  localparam int unsigned WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] TMO_LIM = WCW'(TIMEOUT);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        k_q, k_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [31:0]       rdata_q, rdata_d;

  logic last_beat;
  logic timeout_hit;

  assign last_beat   = ({1'b0, k_q} == (beats_for(size_q) - 3'd1));
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == TMO_LIM);
  assign rdata       = rdata_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    size_d    = size_q;
    k_d       = k_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          size_d  = req_size;
          if (req_bad(req_size, req_addr[1:0])) begin
            err = 1'b1;
          end else begin
            stall   = 1'b1;
            k_d     = 2'd0;
            wait_d  = '0;
            // Stores leave the last load result untouched.
            if (!req_we) rdata_d = '0;
            state_d = S_BEAT;
          end
        end
      end
      S_BEAT: begin
        if (timeout_hit) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall     = 1'b1;
          mem_addr  = addr_q + ADDR_W'(k_q);
          mem_rd_en = !we_q;
          mem_wr_en = we_q;
          mem_wdata = wdata_q[{k_q, 3'b000} +: 8];
          if (mem_ack) begin
            if (!we_q) rdata_d[{k_q, 3'b000} +: 8] = mem_rdata;
            k_d    = k_q + 2'd1;
            wait_d = '0;
            if (last_beat) state_d = S_RESP;
          end else if (TIMEOUT != 0) begin
            wait_d = wait_q + WCW'(1);
          end
        end
      end
      S_RESP: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      k_q     <= 2'd0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: directed cases plus random loads/stores against
// a byte-RAM model with randomized ack delay.
module tb_mem_byte_sequencer;
  import mips_mem_pkg::*;

  localparam int TMO = 4;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  seq_state_t  dbg_state;

  mem_byte_sequencer #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  string cur_tag = "init";

  // scoreboard: {we, addr, byte} per accepted beat
  logic [40:0] exp_q[$];
  logic [40:0] act_q[$];
  logic [7:0]  ram [logic [31:0]];
  int          ack_delay = 0;
  int          ack_cnt = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, name, obs, exp);
    end
  endtask

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    logic [7:0] lo;
    if (ram.exists(a)) return ram[a];
    lo = a[7:0];
    return lo ^ 8'hA5;
  endfunction

  // RAM responder: acks a beat after ack_delay waiting cycles
  always @(negedge clk) begin
    if (!reset_n) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_rd_en || mem_wr_en) begin
      chk("one_strobe", 64'(mem_rd_en & mem_wr_en), 64'd0);
      if (ack_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        ack_cnt = 0;
        if (mem_wr_en) begin
          act_q.push_back({1'b1, mem_addr, mem_wdata});
          ram[mem_addr] = mem_wdata;
          mem_rdata = 8'h00;
        end else begin
          mem_rdata = ram_rd(mem_addr);
          act_q.push_back({1'b0, mem_addr, mem_rdata});
        end
      end else begin
        mem_ack = 1'b0;
        ack_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end
  end

  task automatic check_beats();
    chk("beat_count", 64'(act_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0)
      chk("beat", 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    act_q.delete();
  endtask

  // One access from the IDLE cycle through done or err.
  task automatic run_access(input string tag, input logic we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata, input int delay);
    int          n;
    bit          legal;
    logic [31:0] exp_rd;
    logic [31:0] a;
    logic [31:0] sh;
    logic [7:0]  b;
    int          cyc;
    int          stalls;
    bit          got;
    cur_tag = tag;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    legal = (n != 0) && ((addr % n) == 0);
    exp_rd = 32'd0;
    exp_q.delete();
    act_q.delete();
    if (legal) begin
      for (int k = 0; k < n; k++) begin
        a  = addr + k;
        sh = wdata >> (8 * k);
        b  = we ? sh[7:0] : ram_rd(a);
        exp_q.push_back({we, a, b});
        exp_rd = exp_rd | (32'(b) << (8 * k));
      end
    end
    ack_delay = delay;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    if (!legal) begin
      chk("err_pulse", 64'(err), 64'd1);
      chk("stall_on_err", 64'(stall), 64'd0);
      chk("done_on_err", 64'(done), 64'd0);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("err_one_cycle", 64'(err), 64'd0);
      chk("strobes_off", 64'({mem_rd_en, mem_wr_en}), 64'd0);
      chk("stay_idle", 64'(dbg_state), 64'(S_IDLE));
      chk("no_done", 64'(done), 64'd0);
    end else begin
      chk("accept_stall", 64'(stall), 64'd1);
      chk("accept_err", 64'(err), 64'd0);
      stalls = 1;
      cyc = 0;
      got = 1'b0;
      while (cyc < 60 && !got) begin
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        cyc++;
        if (done) got = 1'b1;
        else if (err) break;
        else stalls += int'(stall);
      end
      chk("done_seen", 64'(got), 64'd1);
      chk("latency", 64'(cyc), 64'(n * (delay + 1) + 1));
      chk("stall_cycles", 64'(stalls), 64'(1 + n * (delay + 1)));
      chk("resp_stall", 64'(stall), 64'd0);
      if (!we) chk("rdata", 64'(rdata), 64'(exp_rd));
    end
    check_beats();
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;
    int          cyc;
    bit          seen_err;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    reset_n   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    #12;
    cur_tag = "reset";
    chk("stall", 64'(stall), 64'd0);
    chk("done", 64'(done), 64'd0);
    chk("err", 64'(err), 64'd0);
    chk("strobes", 64'({mem_rd_en, mem_wr_en}), 64'd0);
    chk("rdata", 64'(rdata), 64'd0);
    chk("mem_addr", 64'(mem_addr), 64'd0);
    chk("mem_wdata", 64'(mem_wdata), 64'd0);
    chk("state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    reset_n = 1'b1;

    // 1: lw at 0x100
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    run_access("lw_100", 1'b0, SZ_WORD, 32'h100, 32'h0, 0);
    chk("lw_value", 64'(rdata), 64'h44332211);
    // 2: sh at 0x202
    run_access("sh_202", 1'b1, SZ_HALF, 32'h202, 32'hAABBCCDD, 0);
    // 3: lbu at 0x7 with slow ack
    ram[32'h7] = 8'hF0;
    run_access("lbu_7", 1'b0, SZ_BYTE, 32'h7, 32'h0, 3);
    chk("lbu_value", 64'(rdata), 64'h000000F0);
    // 4: misaligned and illegal
    run_access("lw_101", 1'b0, SZ_WORD, 32'h101, 32'h0, 0);
    run_access("sh_3", 1'b1, SZ_HALF, 32'h3, 32'h1234, 0);
    run_access("size_11", 1'b0, SZ_ILL, 32'h40, 32'h0, 0);
    chk("rdata_kept", 64'(rdata), 64'h000000F0);

    // 5: timeout with no ack
    cur_tag = "timeout";
    ack_delay = 1000;
    act_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD;
    req_addr = 32'h300; req_wdata = 32'h01020304;
    #1;
    chk("accept_stall", 64'(stall), 64'd1);
    seen_err = 1'b0;
    cyc = 0;
    while (cyc < 40 && !seen_err) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      cyc++;
      chk("no_done", 64'(done), 64'd0);
      if (err) seen_err = 1'b1;
    end
    chk("err_seen", 64'(seen_err), 64'd1);
    chk("err_cycle", 64'(cyc), 64'(TMO + 1));
    chk("stall_dropped", 64'(stall), 64'd0);
    chk("strobes_dropped", 64'({mem_rd_en, mem_wr_en}), 64'd0);
    @(negedge clk);
    #1;
    chk("idle_after", 64'(dbg_state), 64'(S_IDLE));
    chk("err_one_cycle", 64'(err), 64'd0);
    chk("no_writes", 64'(act_q.size()), 64'd0);
    act_q.delete();

    // random loads/stores, back to back
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FF0);
      ad = ad | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 7) begin
        if (sz == SZ_HALF) ad[0] = 1'b0;
        if (sz == SZ_WORD) ad[1:0] = 2'b00;
      end
      run_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz, ad, $urandom,
                 $urandom_range(0, 2));
    end

    // 6: reset during beat 2 of sw
    run_access("lw_pre", 1'b0, SZ_WORD, 32'h100, 32'h0, 0);
    cur_tag = "reset_mid";
    ack_delay = 0;
    act_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("stall", 64'(stall), 64'd0);
    chk("done", 64'(done), 64'd0);
    chk("err", 64'(err), 64'd0);
    chk("strobes", 64'({mem_rd_en, mem_wr_en}), 64'd0);
    chk("mem_addr", 64'(mem_addr), 64'd0);
    chk("mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rdata", 64'(rdata), 64'd0);
    chk("state", 64'(dbg_state), 64'(S_IDLE));
    chk("beats_before", 64'(act_q.size()), 64'd1);
    if (act_q.size() > 0) chk("first_beat", 64'(act_q[0]), 64'({1'b1, 32'h40, 8'h0D}));
    act_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_access("lbu_after", 1'b0, SZ_BYTE, 32'h41, 32'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
